// File: rtl/stack_arith_unit.sv
// Stack-based arithmetic unit: PUSH/POP on a small register stack plus a
// multi-cycle signed ALU (ADD/SUB/MUL/DIV) that consumes the top two entries.
module stack_arith_unit #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   input  logic [2:0]               cmd_op,
   input  logic [WIDTH-1:0]         cmd_data,
   output logic                     cmd_ready,
   output logic                     done,
   output logic                     err,
   output logic [WIDTH-1:0]         tos,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     empty,
   output logic                     full,
   output logic                     carryOut
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = AW + 1;

   localparam logic [2:0] OP_PUSH = 3'd1;
   localparam logic [2:0] OP_POP  = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_MUL  = 3'd5;
   localparam logic [2:0] OP_DIV  = 3'd6;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_PUSH
   } state_t;

   state_t            state;
   logic [2:0]        op_q;
   logic [WIDTH-1:0]  in1;
   logic [WIDTH-1:0]  in2;
   logic [WIDTH-1:0]  result_q;

   logic [WIDTH-1:0]  stack [DEPTH];

   logic              accept;
   logic [AW-1:0]     top_idx;
   logic [AW-1:0]     sec_idx;

   logic              wr_en;
   logic [AW-1:0]     wr_idx;
   logic [WIDTH-1:0]  wr_data;

   logic [WIDTH:0]           sum_w;
   logic signed [2*WIDTH-1:0] prod_w;
   logic signed [WIDTH-1:0]  den_w;
   logic signed [WIDTH-1:0]  quot_w;
   logic [WIDTH-1:0]         alu_res;
   logic                     alu_cy;

   assign accept  = cmd_valid & cmd_ready;
   assign top_idx = AW'(depth - DW'(1));
   assign sec_idx = AW'(depth - DW'(2));

   // Signed ALU on the latched operands; in1 is the top of stack
   always_comb begin
      sum_w   = {1'b0, in1} + {1'b0, in2};
      prod_w  = $signed({{WIDTH{in1[WIDTH-1]}}, in1}) * $signed({{WIDTH{in2[WIDTH-1]}}, in2});
      den_w   = (in2 == '0) ? $signed(WIDTH'(1)) : $signed(in2);
      quot_w  = $signed(in1) / den_w;
      alu_res = sum_w[WIDTH-1:0];
      alu_cy  = sum_w[WIDTH];
      case (op_q)
         OP_SUB: begin
            alu_res = in1 - in2;
            alu_cy  = (in1 < in2);
         end
         OP_MUL: begin
            alu_res = prod_w[WIDTH-1:0];
            alu_cy  = (prod_w[2*WIDTH-1:WIDTH-1] != '0) && (prod_w[2*WIDTH-1:WIDTH-1] != '1);
         end
         OP_DIV: begin
            if (in1 == MOST_NEG && in2 == '1) begin
               alu_res = MOST_NEG;
               alu_cy  = 1'b1;
            end else begin
               alu_res = quot_w;
               alu_cy  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Stack write port: accepted PUSH or ALU write-back
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = '0;
      if (state == S_IDLE && accept && cmd_op == OP_PUSH && !full) begin
         wr_en   = 1'b1;
         wr_idx  = AW'(depth);
         wr_data = cmd_data;
      end else if (state == S_PUSH) begin
         wr_en   = 1'b1;
         wr_idx  = sec_idx;
         wr_data = result_q;
      end
   end

   // Storage is not reset; depth alone defines which entries are valid
   always_ff @(posedge clk) begin
      if (wr_en) stack[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         op_q      <= '0;
         in1       <= '0;
         in2       <= '0;
         result_q  <= '0;
         cmd_ready <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         tos       <= '0;
         depth     <= '0;
         empty     <= 1'b1;
         full      <= 1'b0;
         carryOut  <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (accept) begin
                  case (cmd_op)
                     OP_PUSH: begin
                        done <= 1'b1;
                        if (full) begin
                           err <= 1'b1;
                        end else begin
                           depth <= depth + DW'(1);
                           empty <= 1'b0;
                           full  <= (depth + DW'(1) == DW'(DEPTH));
                           tos   <= cmd_data;
                        end
                     end
                     OP_POP: begin
                        done <= 1'b1;
                        if (empty) begin
                           err <= 1'b1;
                        end else begin
                           depth <= depth - DW'(1);
                           empty <= (depth == DW'(1));
                           full  <= 1'b0;
                           tos   <= (depth >= DW'(2)) ? stack[sec_idx] : '0;
                        end
                     end
                     OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                        if (depth < DW'(2)) begin
                           done <= 1'b1;
                           err  <= 1'b1;
                        end else begin
                           op_q      <= cmd_op;
                           state     <= S_FETCH;
                           cmd_ready <= 1'b0;
                        end
                     end
                     default: done <= 1'b1;
                  endcase
               end
            end
            S_FETCH: begin
               in1   <= stack[top_idx];
               in2   <= stack[sec_idx];
               state <= S_EXEC;
            end
            S_EXEC: begin
               // Divide by zero is rejected before any state is touched
               if (op_q == OP_DIV && in2 == '0) begin
                  done      <= 1'b1;
                  err       <= 1'b1;
                  state     <= S_IDLE;
                  cmd_ready <= 1'b1;
               end else begin
                  result_q <= alu_res;
                  carryOut <= alu_cy;
                  state    <= S_PUSH;
               end
            end
            S_PUSH: begin
               depth     <= depth - DW'(1);
               empty     <= (depth == DW'(1));
               full      <= 1'b0;
               tos       <= result_q;
               done      <= 1'b1;
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_arith_unit.sv
// Scoreboard bench for stack_arith_unit: an integer stack model predicts each
// completion; a negedge monitor pops and compares on every done pulse.
module tb_stack_arith_unit;

   localparam int DEPTH = 8;
   localparam int W     = 8;

   localparam int OP_NOP  = 0;
   localparam int OP_PUSH = 1;
   localparam int OP_POP  = 2;
   localparam int OP_ADD  = 3;
   localparam int OP_SUB  = 4;
   localparam int OP_MUL  = 5;
   localparam int OP_DIV  = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic [2:0]    cmd_op;
   logic [W-1:0]  cmd_data;
   logic          cmd_ready;
   logic          done;
   logic          err;
   logic [W-1:0]  tos;
   logic [3:0]    depth;
   logic          empty;
   logic          full;
   logic          carryOut;

   stack_arith_unit #(.DEPTH(DEPTH), .WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_ready (cmd_ready),
      .done      (done),
      .err       (err),
      .tos       (tos),
      .depth     (depth),
      .empty     (empty),
      .full      (full),
      .carryOut  (carryOut)
   );

   always #5 clk = ~clk;

   typedef struct {
      int err;
      int tos;
      int depth;
      int carry;
      int lat;
      int acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   stk[$];
   int   m_carry = 0;
   int   cyc     = 0;
   int   n_cmp   = 0;
   int   n_bad   = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   function automatic int to_s(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   // Reference: operate on the integer stack with plain signed arithmetic
   task automatic model_step(input int op, input int data);
      exp_t e;
      int a, b, sa, sb_v, r, c, p;
      e.err = 0; e.lat = 1; e.acc = cyc;
      case (op)
         OP_PUSH: if (stk.size() == DEPTH) e.err = 1; else stk.push_back(data & 255);
         OP_POP:  if (stk.size() == 0) e.err = 1; else void'(stk.pop_back());
         OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
            if (stk.size() < 2) begin
               e.err = 1;
            end else begin
               a = stk[stk.size()-1]; b = stk[stk.size()-2];
               sa = to_s(a); sb_v = to_s(b);
               r = 0; c = 0;
               if (op == OP_ADD) begin
                  r = (a + b) & 255; c = (a + b > 255) ? 1 : 0;
               end else if (op == OP_SUB) begin
                  r = (a - b) & 255; c = (a < b) ? 1 : 0;
               end else if (op == OP_MUL) begin
                  p = sa * sb_v; r = p & 255; c = (p < -128 || p > 127) ? 1 : 0;
               end else if (b != 0) begin
                  if (sa == -128 && sb_v == -1) begin r = 128; c = 1; end
                  else begin r = (sa / sb_v) & 255; c = 0; end
               end
               if (op == OP_DIV && b == 0) begin
                  e.err = 1; e.lat = 0;
               end else begin
                  void'(stk.pop_back()); void'(stk.pop_back());
                  stk.push_back(r);
                  m_carry = c;
                  e.lat = 4;
               end
            end
         end
         default: ;
      endcase
      e.tos   = (stk.size() > 0) ? stk[stk.size()-1] : 0;
      e.depth = stk.size();
      e.carry = m_carry;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (err && !done) begin
         n_cmp++; n_bad++;
         $display("FAIL err_without_done: got err=1 done=0, required err only with done");
      end
      if (done) begin
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got done=1, required no pending completion (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            chk("err",   int'(err),      mon_e.err);
            chk("tos",   int'(tos),      mon_e.tos);
            chk("depth", int'(depth),    mon_e.depth);
            chk("empty", int'(empty),    (mon_e.depth == 0) ? 1 : 0);
            chk("full",  int'(full),     (mon_e.depth == DEPTH) ? 1 : 0);
            chk("carry", int'(carryOut), mon_e.carry);
            if (mon_e.lat != 0) chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
         end
      end
   end

   task automatic wait_ready(output bit ok);
      int w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 60) begin @(negedge clk); w++; end
      ok = cmd_ready;
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL ready_timeout: got cmd_ready=0, required 1 within 60 cycles");
      end
   endtask

   // noisy: keep cmd_valid asserted while the ALU is busy; it must be ignored
   task automatic issue(input int op, input int data, input bit noisy);
      bit ok;
      bit busy;
      wait_ready(ok);
      if (!ok) return;
      busy = (op >= OP_ADD && op <= OP_DIV && stk.size() >= 2);
      cmd_valid = 1'b1; cmd_op = 3'(op); cmd_data = 8'(data);
      @(posedge clk); #1;
      model_step(op, data);
      if (noisy && busy) begin
         cmd_op = 3'(OP_PUSH); cmd_data = 8'h5A;
         @(posedge clk); @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic settle();
      int w = 0;
      while (sb.size() != 0 && w < 100) begin @(negedge clk); w++; end
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL settle_timeout: got %0d pending, required 0", sb.size());
      end
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ready"}, int'(cmd_ready), 0);
      chk({tag, "_done"},  int'(done),      0);
      chk({tag, "_err"},   int'(err),       0);
      chk({tag, "_depth"}, int'(depth),     0);
      chk({tag, "_empty"}, int'(empty),     1);
      chk({tag, "_full"},  int'(full),      0);
      chk({tag, "_tos"},   int'(tos),       0);
      chk({tag, "_carry"}, int'(carryOut),  0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
      #1 chk("ready_before_edge", int'(cmd_ready), 0);
      @(posedge clk); #1;
      chk("ready_after_edge", int'(cmd_ready), 1);
   endtask

   task automatic do_reset();
      settle();
      reset = 1'b0;
      stk.delete(); m_carry = 0;
      @(negedge clk);
      check_reset_vals("rst");
      release_reset();
   endtask

   task automatic directed(input int a, input int b, input int op, input int etos, input int ecy);
      do_reset();
      issue(OP_PUSH, a, 1'b0);
      issue(OP_PUSH, b, 1'b0);
      issue(op, 0, 1'b0);
      settle();
      chk("dir_tos",   int'(tos),      etos);
      chk("dir_carry", int'(carryOut), ecy);
      chk("dir_depth", int'(depth),    1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int r, op, data;
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("init");
      release_reset();

      directed(7,    2,    OP_ADD, 9,    0);
      directed(8'hEE, 8'h11, OP_ADD, 8'hFF, 0);
      directed(8'hFF, 8'h12, OP_MUL, 8'hEE, 0);
      directed(6,    4,    OP_SUB, 8'hFE, 1);
      directed(2,    8,    OP_SUB, 6,    0);
      directed(27,   54,   OP_DIV, 2,    0);
      directed(8'hFE, 2,    OP_DIV, 8'hFF, 0);
      directed(8'hFF, 2,    OP_ADD, 1,    1);
      directed(16,   16,   OP_MUL, 0,    1);
      directed(8'hFF, 8'h80, OP_DIV, 8'h80, 1);

      // Divide by zero, rejected ALU on short stack, NOP codes
      do_reset();
      issue(OP_PUSH, 0, 1'b0); issue(OP_PUSH, 5, 1'b0);
      issue(OP_DIV, 0, 1'b0);
      settle();
      chk("div0_depth", int'(depth), 2);
      chk("div0_tos",   int'(tos),   5);
      issue(OP_POP, 0, 1'b0); issue(OP_MUL, 0, 1'b0);
      issue(OP_NOP, 0, 1'b0); issue(7, 0, 1'b0);

      // Overfill, then drain past empty
      do_reset();
      for (int i = 0; i <= DEPTH; i++) issue(OP_PUSH, i * 3 + 1, 1'b0);
      settle();
      chk("fill_full",  int'(full),  1);
      chk("fill_depth", int'(depth), DEPTH);
      for (int i = 0; i <= DEPTH; i++) issue(OP_POP, 0, 1'b0);
      settle();
      chk("drain_empty", int'(empty), 1);

      // Reset during EXEC aborts the command without a completion
      do_reset();
      issue(OP_PUSH, 3, 1'b0); issue(OP_PUSH, 4, 1'b0);
      settle();
      wait_ready(ok);
      cmd_valid = 1'b1; cmd_op = 3'(OP_ADD); cmd_data = '0;
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0;
      stk.delete(); m_carry = 0;
      #1 check_reset_vals("abort");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_done", int'(done), 0);
      end
      release_reset();

      // Randomized command stream with occasional ignored requests while busy
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4)       op = OP_PUSH;
         else if (r == 4) op = OP_POP;
         else if (r < 9)  op = $urandom_range(OP_ADD, OP_DIV);
         else             op = ($urandom_range(0, 1) == 0) ? OP_NOP : 7;
         case ($urandom_range(0, 4))
            0:       data = $urandom_range(0, 2);
            1:       data = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'hFF;
            default: data = $urandom_range(0, 255);
         endcase
         issue(op, data, ($urandom_range(0, 3) == 0));
      end
      settle();
      chk("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
